// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4 -- four-slot TDM word-stream demultiplexer
//
// Collects a serial stream of WIDTH-bit words into four slots, using
// frame_sync to find slot 0. Complete frames are presented on ch0..ch3_data
// with a one-cycle frame_valid pulse. A partial frame never reaches the
// outputs.
//
// Build option:
//   TDM_DEMUX_SYNC_CHECK_EN  when defined, frame_sync is checked while LOCKED:
//                            - sync at slot 1..3 restarts the frame at slot 0
//                            - no sync at slot 0 drops the word and re-hunts
//                            Each case pulses sync_err.
//                            When undefined, slots free-run once locked and
//                            sync_err is tied to 0.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   din          in   [WIDTH-1:0] TDM word
//   din_valid    in   din carries a word this cycle
//   frame_sync   in   current valid word is slot 0
//   ch0..3_data  out  [WIDTH-1:0] slot words of the last complete frame
//   frame_valid  out  one-cycle pulse when ch0..3_data update
//   locked       out  FSM is in LOCKED
//   sync_err     out  one-cycle pulse on a framing violation
// -----------------------------------------------------------------------------
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] ch0_data,
  output logic [WIDTH-1:0] ch1_data,
  output logic [WIDTH-1:0] ch2_data,
  output logic [WIDTH-1:0] ch3_data,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t     state, state_nx;
  logic [1:0] slot_cnt, slot_cnt_nx;

  logic       wr_en;
  logic [1:0] wr_slot;
  logic       frame_done;
  logic       err_c;

  logic [WIDTH-1:0] stg_p0 [4];

  // ---------------------------------------------------------------------------
  // Control: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      slot_cnt <= 2'd0;
    end else begin
      state    <= state_nx;
      slot_cnt <= slot_cnt_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Control: next state, staging write strobe, frame completion
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx    = state;
    slot_cnt_nx = slot_cnt;
    wr_en       = 1'b0;
    wr_slot     = 2'd0;
    frame_done  = 1'b0;
    err_c       = 1'b0;

    unique case (state)
      HUNT: begin
        if (din_valid && frame_sync) begin
          wr_en       = 1'b1;
          wr_slot     = 2'd0;
          slot_cnt_nx = 2'd1;
          state_nx    = LOCKED;
        end
      end

      LOCKED: begin
        if (din_valid) begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
          if (frame_sync && (slot_cnt != 2'd0)) begin
            // Early sync: abandon the partial frame and restart at slot 0.
            err_c       = 1'b1;
            wr_en       = 1'b1;
            wr_slot     = 2'd0;
            slot_cnt_nx = 2'd1;
          end else if (!frame_sync && (slot_cnt == 2'd0)) begin
            // Missing sync: word is dropped and alignment is searched again.
            err_c       = 1'b1;
            slot_cnt_nx = 2'd0;
            state_nx    = HUNT;
          end else begin
            wr_en       = 1'b1;
            wr_slot     = slot_cnt;
            slot_cnt_nx = slot_cnt + 2'd1;
            frame_done  = (slot_cnt == 2'd3);
          end
`else
          wr_en       = 1'b1;
          wr_slot     = slot_cnt;
          slot_cnt_nx = slot_cnt + 2'd1;
          frame_done  = (slot_cnt == 2'd3);
`endif
        end
      end

      default: begin
        state_nx    = HUNT;
        slot_cnt_nx = 2'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Data: staging (p0) and frame output (p1)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) stg_p0[i] <= '0;
      ch0_data    <= '0;
      ch1_data    <= '0;
      ch2_data    <= '0;
      ch3_data    <= '0;
      frame_valid <= 1'b0;
    end else begin
      if (wr_en) stg_p0[wr_slot] <= din;
      // Slot 3 is taken straight from din so the whole frame lands in one edge.
      if (frame_done) begin
        ch0_data <= stg_p0[0];
        ch1_data <= stg_p0[1];
        ch2_data <= stg_p0[2];
        ch3_data <= din;
      end
      frame_valid <= frame_done;
    end
  end

  assign locked = (state == LOCKED);

  // sync_err is flagged in the cycle of the offending word, while still
  // LOCKED, so it is never high in HUNT even when the error causes a re-hunt.
  assign sync_err = err_c;

endmodule
